// File: rtl/vector_alu_sequencer_if.sv
// Shared opcode type plus the issue / register-file / ALU / writeback bundle
// between decode, the vector ALU sequencer and the vector register file.
package vector_alu_sequencer_pkg;
  localparam int XLEN = 32;
  typedef logic [5:0] alu_opcodes;
endpackage

interface vector_alu_sequencer_if #(
  parameter int VLEN = 1024
);
  import vector_alu_sequencer_pkg::*;
  localparam int NB  = VLEN / 256;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int VLW = $clog2(VLEN / 8) + 1;

  // issue side
  logic            issue_valid_i;
  logic            issue_ready_o;
  alu_opcodes      issue_opcode_i;
  logic [2:0]      issue_sew_i;
  logic [VLW-1:0]  issue_vl_i;
  logic [4:0]      issue_vs1_i, issue_vs2_i, issue_vd_i;
  logic            issue_signed_i, issue_use_mask_i, issue_use_carry_i;
  logic            issue_produce_carry_i, issue_saturate_i, issue_en_addsub_i;
  logic [VLEN-1:0] v0_i;
  // register-file read
  logic            rf_rd_en_o;
  logic [4:0]      rf_rd_addr1_o, rf_rd_addr2_o;
  logic [BW-1:0]   rf_rd_beat_o;
  logic            rf_gnt_i;
  // ALU control
  logic [2:0]      alu_sew_o;
  alu_opcodes      alu_opcode_o;
  logic            alu_signed_o, alu_use_mask_o, alu_use_carry_o;
  logic            alu_produce_carry_o, alu_saturate_o, alu_en_addsub_o;
  logic [255:0]    alu_v0_o;
  // writeback / completion
  logic            wb_en_o;
  logic [4:0]      wb_addr_o;
  logic [BW-1:0]   wb_beat_o;
  logic [31:0]     wb_be_o;
  logic            done_o, err_o;

  modport master (
    output issue_valid_i, issue_opcode_i, issue_sew_i, issue_vl_i,
           issue_vs1_i, issue_vs2_i, issue_vd_i, issue_signed_i, issue_use_mask_i,
           issue_use_carry_i, issue_produce_carry_i, issue_saturate_i,
           issue_en_addsub_i, v0_i, rf_gnt_i,
    input  issue_ready_o, rf_rd_en_o, rf_rd_addr1_o, rf_rd_addr2_o, rf_rd_beat_o,
           alu_sew_o, alu_opcode_o, alu_signed_o, alu_use_mask_o, alu_use_carry_o,
           alu_produce_carry_o, alu_saturate_o, alu_en_addsub_o, alu_v0_o,
           wb_en_o, wb_addr_o, wb_beat_o, wb_be_o, done_o, err_o
  );

  modport slave (
    input  issue_valid_i, issue_opcode_i, issue_sew_i, issue_vl_i,
           issue_vs1_i, issue_vs2_i, issue_vd_i, issue_signed_i, issue_use_mask_i,
           issue_use_carry_i, issue_produce_carry_i, issue_saturate_i,
           issue_en_addsub_i, v0_i, rf_gnt_i,
    output issue_ready_o, rf_rd_en_o, rf_rd_addr1_o, rf_rd_addr2_o, rf_rd_beat_o,
           alu_sew_o, alu_opcode_o, alu_signed_o, alu_use_mask_o, alu_use_carry_o,
           alu_produce_carry_o, alu_saturate_o, alu_en_addsub_o, alu_v0_o,
           wb_en_o, wb_addr_o, wb_beat_o, wb_be_o, done_o, err_o
  );
endinterface

// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: takes one instruction, walks its 256-bit beats through
// a read -> execute/writeback pipeline and pulses done when the last beat retires.
module vector_alu_sequencer
  import vector_alu_sequencer_pkg::*;
#(
  parameter int XLEN = vector_alu_sequencer_pkg::XLEN,
  parameter int VLEN = 1024
) (
  input logic                  clk_i,
  input logic                  rst_i,
  vector_alu_sequencer_if.slave bus
);
  localparam int NB  = VLEN / 256;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int VLW = $clog2(VLEN / 8) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [1:0]      sew_q;      // legal SEW only; illegal instructions never reach RUN
  logic [VLW-1:0]  vl_q, nb_q;
  logic [4:0]      vs1_q, vs2_q, vd_q;
  logic            err_q, addsub_q;
  logic [VLEN-1:0] v0_q;
  logic [BW-1:0]   b_q, ex_beat;
  logic            ex_vld;

  // accept-time decode: clamp vl to VLMAX and count beats
  logic            legal;
  logic [1:0]      s_in;
  logic [VLW-1:0]  vlmax, vl_eff, nbeats;
  logic [VLW:0]    rnd;
  always_comb begin
    legal  = (bus.issue_sew_i < 3'd4);
    s_in   = bus.issue_sew_i[1:0];
    vlmax  = VLW'(VLEN >> (3 + int'(s_in)));
    vl_eff = '0;
    if (legal) vl_eff = (bus.issue_vl_i < vlmax) ? bus.issue_vl_i : vlmax;
    rnd    = {1'b0, vl_eff} + (VLW+1)'((32 >> s_in) - 1);
    nbeats = VLW'(rnd >> (5 - int'(s_in)));
  end

  // grant-time beat shaping: mask slice, element enables, byte enables
  logic [VLW-1:0]  base;
  logic [XLEN-1:0] slice, v0n, en;
  logic [31:0]     be_n;
  always_comb begin
    base  = VLW'({b_q, 5'b0} >> sew_q);
    slice = XLEN'(v0_q >> base);
    v0n   = '0;
    en    = '0;
    be_n  = '0;
    for (int k = 0; k < XLEN; k++) begin
      if (k < (32 >> sew_q)) begin
        v0n[k] = slice[k];
        en[k]  = ((int'(base) + k) < int'(vl_q)) && (bus.alu_use_mask_o || slice[k]);
      end
    end
    for (int j = 0; j < 32; j++) be_n[j] = en[j >> sew_q];
  end

  // sequencing FSM, operand latches and the single exec/writeback stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                   <= IDLE;
      sew_q                   <= '0;
      vl_q                    <= '0;
      nb_q                    <= '0;
      vs1_q                   <= '0;
      vs2_q                   <= '0;
      vd_q                    <= '0;
      err_q                   <= 1'b0;
      addsub_q                <= 1'b0;
      v0_q                    <= '0;
      b_q                     <= '0;
      ex_beat                 <= '0;
      ex_vld                  <= 1'b0;
      bus.alu_sew_o           <= '0;
      bus.alu_opcode_o        <= '0;
      bus.alu_signed_o        <= 1'b0;
      bus.alu_use_mask_o      <= 1'b0;
      bus.alu_use_carry_o     <= 1'b0;
      bus.alu_produce_carry_o <= 1'b0;
      bus.alu_saturate_o      <= 1'b0;
      bus.alu_v0_o            <= '0;
      bus.wb_be_o             <= '0;
    end else begin
      ex_vld       <= 1'b0;
      bus.alu_v0_o <= '0;
      bus.wb_be_o  <= '0;
      unique case (state)
        IDLE: if (bus.issue_valid_i) begin
          sew_q                   <= s_in;
          vl_q                    <= vl_eff;
          nb_q                    <= nbeats;
          vs1_q                   <= bus.issue_vs1_i;
          vs2_q                   <= bus.issue_vs2_i;
          vd_q                    <= bus.issue_vd_i;
          err_q                   <= !legal;
          addsub_q                <= bus.issue_en_addsub_i;
          v0_q                    <= bus.v0_i;
          b_q                     <= '0;
          bus.alu_sew_o           <= bus.issue_sew_i;
          bus.alu_opcode_o        <= bus.issue_opcode_i;
          bus.alu_signed_o        <= bus.issue_signed_i;
          bus.alu_use_mask_o      <= bus.issue_use_mask_i;
          bus.alu_use_carry_o     <= bus.issue_use_carry_i;
          bus.alu_produce_carry_o <= bus.issue_produce_carry_i;
          bus.alu_saturate_o      <= bus.issue_saturate_i;
          state                   <= (nbeats != '0) ? RUN : DRAIN;
        end
        RUN: if (bus.rf_gnt_i) begin
          ex_vld       <= 1'b1;
          ex_beat      <= b_q;
          bus.wb_be_o  <= be_n;
          bus.alu_v0_o <= {{(256-XLEN){1'b0}}, v0n};
          b_q          <= b_q + 1'b1;
          if (VLW'(b_q) == nb_q - 1'b1) state <= DRAIN;
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.issue_ready_o   = (state == IDLE);
  assign bus.rf_rd_en_o      = (state == RUN);
  assign bus.rf_rd_addr1_o   = vs1_q;
  assign bus.rf_rd_addr2_o   = vs2_q;
  assign bus.rf_rd_beat_o    = b_q;
  assign bus.alu_en_addsub_o = addsub_q & ex_vld;
  assign bus.wb_en_o         = ex_vld;
  assign bus.wb_addr_o       = vd_q;
  assign bus.wb_beat_o       = ex_beat;
  assign bus.done_o          = (state == DRAIN);
  assign bus.err_o           = (state == DRAIN) & err_q;
endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer: each step issues one instruction,
// logs 15 cycles of pipeline activity, then compares against hand values.
module tb_vector_alu_sequencer;
  localparam int VLEN = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  vector_alu_sequencer_if #(.VLEN(VLEN)) bus ();
  vector_alu_sequencer #(.VLEN(VLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] rd_m, rden_m, wb_m, done_m, err_m, rdy_m;
  logic [31:0] be_log [4];
  logic [63:0] v0_log [4];
  logic [4:0]  wbaddr_log, ra1_log, ra2_log;
  logic        addsub_log, nz4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bus.rf_rd_en_o, bus.rf_rd_addr1_o, bus.rf_rd_addr2_o, bus.rf_rd_beat_o,
             bus.alu_sew_o, bus.alu_opcode_o, bus.alu_signed_o, bus.alu_use_mask_o,
             bus.alu_use_carry_o, bus.alu_produce_carry_o, bus.alu_saturate_o,
             bus.alu_en_addsub_o, bus.alu_v0_o, bus.wb_en_o, bus.wb_addr_o,
             bus.wb_beat_o, bus.wb_be_o, bus.done_o, bus.err_o};
  endfunction

  // Offer one instruction in the current cycle (cycle 0), then log cycles 1..15.
  task automatic run(input logic [2:0] sew, input logic [7:0] vl, input logic um,
                     input logic [15:0] gnt_m, input logic [15:0] rst_m);
    bus.issue_sew_i = sew;
    bus.issue_vl_i = vl;
    bus.issue_use_mask_i = um;
    bus.issue_valid_i = 1'b1;
    {rd_m, rden_m, wb_m, done_m, err_m, rdy_m} = '0;
    for (int i = 0; i < 4; i++) begin be_log[i] = '0; v0_log[i] = '0; end
    wbaddr_log = '0; ra1_log = '0; ra2_log = '0; addsub_log = 1'b0; nz4 = 1'b1;
    @(posedge clk); #1;
    bus.issue_valid_i = 1'b0;
    for (int c = 1; c < 16; c++) begin
      bus.rf_gnt_i = gnt_m[c];
      rst = rst_m[c];
      @(negedge clk);
      rden_m[c] = bus.rf_rd_en_o;
      rd_m[c]   = bus.rf_rd_en_o & bus.rf_gnt_i;
      wb_m[c]   = bus.wb_en_o;
      done_m[c] = bus.done_o;
      err_m[c]  = bus.err_o;
      rdy_m[c]  = bus.issue_ready_o;
      if (bus.rf_rd_en_o && bus.rf_gnt_i) begin
        ra1_log = bus.rf_rd_addr1_o; ra2_log = bus.rf_rd_addr2_o;
      end
      if (bus.wb_en_o) begin
        be_log[bus.wb_beat_o] = bus.wb_be_o;
        v0_log[bus.wb_beat_o] = bus.alu_v0_o[63:0];
        wbaddr_log = bus.wb_addr_o;
        addsub_log = bus.alu_en_addsub_o;
      end
      if (c == 4) nz4 = any_out();
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.rf_gnt_i = 1'b0;
  endtask

  initial begin
    bus.issue_valid_i = 1'b0; bus.issue_opcode_i = '0; bus.issue_sew_i = '0;
    bus.issue_vl_i = '0; bus.issue_vs1_i = '0; bus.issue_vs2_i = '0; bus.issue_vd_i = '0;
    bus.issue_signed_i = 1'b0; bus.issue_use_mask_i = 1'b1; bus.issue_use_carry_i = 1'b0;
    bus.issue_produce_carry_i = 1'b0; bus.issue_saturate_i = 1'b0;
    bus.issue_en_addsub_i = 1'b0; bus.v0_i = '0; bus.rf_gnt_i = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus.issue_ready_o, 1'b1);
    chk("reset_outs_zero", any_out(), 1'b0);
    @(posedge clk); #1;

    // e32 vl=8 unmasked, single beat
    bus.issue_vs1_i = 5'd1; bus.issue_vs2_i = 5'd2; bus.issue_vd_i = 5'd3;
    bus.issue_en_addsub_i = 1'b1; bus.issue_opcode_i = 6'h11;
    run(3'd2, 8'd8, 1'b1, 16'hFFFF, 16'h0000);
    chk("e32_rd", rd_m, 16'h0002);
    chk("e32_wb", wb_m, 16'h0004);
    chk("e32_done", done_m, 16'h0004);
    chk("e32_ready", rdy_m, 16'hFFF8);
    chk("e32_be0", be_log[0], 32'hFFFFFFFF);
    chk("e32_wbaddr", wbaddr_log, 5'd3);
    chk("e32_rdaddr", {ra1_log, ra2_log}, {5'd1, 5'd2});
    chk("e32_addsub", addsub_log, 1'b1);
    chk("e32_sew_held", bus.alu_sew_o, 3'd2);
    chk("e32_opc_held", bus.alu_opcode_o, 6'h11);
    chk("e32_addsub_idle", bus.alu_en_addsub_o, 1'b0);

    // e8 vl=100: four beats, partial last beat
    bus.issue_en_addsub_i = 1'b0;
    run(3'd0, 8'd100, 1'b1, 16'hFFFF, 16'h0000);
    chk("e8_rd", rd_m, 16'h001E);
    chk("e8_wb", wb_m, 16'h003C);
    chk("e8_done", done_m, 16'h0020);
    chk("e8_ready", rdy_m, 16'hFFC0);
    chk("e8_be0", be_log[0], 32'hFFFFFFFF);
    chk("e8_be1", be_log[1], 32'hFFFFFFFF);
    chk("e8_be2", be_log[2], 32'hFFFFFFFF);
    chk("e8_be3", be_log[3], 32'h0000000F);

    // e64 vl=20 clamps to 16, grant low on cycles 2 and 3
    run(3'd3, 8'd20, 1'b1, 16'hFFF3, 16'h0000);
    chk("e64_rden", rden_m, 16'h007E);
    chk("e64_rd", rd_m, 16'h0072);
    chk("e64_wb", wb_m, 16'h00E4);
    chk("e64_done", done_m, 16'h0080);
    chk("e64_be", {be_log[0] & be_log[1], be_log[2] & be_log[3]}, 64'hFFFFFFFF_FFFFFFFF);

    // e16 vl=16 masked, vs1 = vd
    bus.v0_i = '0;
    bus.v0_i[31:0] = 32'h5A5AA5A5;
    bus.issue_vs1_i = 5'd5; bus.issue_vd_i = 5'd5;
    run(3'd1, 8'd16, 1'b0, 16'hFFFF, 16'h0000);
    chk("e16m_wb", wb_m, 16'h0004);
    chk("e16m_done", done_m, 16'h0004);
    chk("e16m_v0", v0_log[0], 64'h00000000_0000A5A5);
    chk("e16m_be", be_log[0], 32'hCC33CC33);
    chk("e16m_mask_held", bus.alu_use_mask_o, 1'b0);

    // illegal SEW
    run(3'd5, 8'd10, 1'b1, 16'hFFFF, 16'h0000);
    chk("ill_rd", rden_m, 16'h0000);
    chk("ill_wb", wb_m, 16'h0000);
    chk("ill_done", done_m, 16'h0002);
    chk("ill_err", err_m, 16'h0002);
    chk("ill_ready", rdy_m, 16'hFFFC);

    // e8 vl=128 with reset in cycle 3
    bus.issue_opcode_i = 6'h2A; bus.issue_vd_i = 5'd7; bus.issue_signed_i = 1'b1;
    run(3'd0, 8'd128, 1'b1, 16'hFFFF, 16'h0008);
    chk("rst_wb", wb_m, 16'h000C);
    chk("rst_done", done_m, 16'h0000);
    chk("rst_ready", rdy_m, 16'hFFF0);
    chk("rst_outs_zero", nz4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_alu_sequencer.md
# vector_alu_sequencer

- Accepts one vector ALU instruction at a time and splits it into 256-bit beats of a VLEN-bit vector register.
- Per beat: requests register-file operand reads, drives the vector ALU's control inputs and v0 slice in the execute cycle, and issues a byte-enabled writeback with tail and mask gating.
- Sits between the decode/issue stage and the vector ALU / vector register file.

## Interface

Parameters:
- XLEN, 32, scalar width (matches package)
- VLEN, 1024, vector register length in bits; beats per register NB = VLEN/256 (must be ≥1, power of 2)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- issue_valid_i  in  1  instruction offered
- issue_ready_o  out  1  high only in IDLE
- issue_opcode_i  in  alu_opcodes  ALU opcode
- issue_sew_i  in  3  0=e8, 1=e16, 2=e32, 3=e64, 4..7 illegal
- issue_vl_i  in  $clog2(VLEN/8)+1  requested vector length
- issue_vs1_i, issue_vs2_i, issue_vd_i  in  5 each  register indices
- issue_signed_i, issue_use_mask_i, issue_use_carry_i, issue_produce_carry_i, issue_saturate_i, issue_en_addsub_i  in  1 each  ALU flags (use_mask: 0 = masked, 1 = unmasked)
- v0_i  in  VLEN  mask register contents, sampled at accept
- rf_rd_en_o  out  1  operand read request
- rf_rd_addr1_o, rf_rd_addr2_o  out  5  vs1/vs2 index
- rf_rd_beat_o  out  $clog2(NB)  beat index
- rf_gnt_i  in  1  read accepted this cycle; data valid next cycle
- alu_sew_o  out  3; alu_opcode_o  out  alu_opcodes; alu_signed_o, alu_use_mask_o, alu_use_carry_o, alu_produce_carry_o, alu_saturate_o  out  1  ALU control, held from accept until next accept
- alu_en_addsub_o  out  1  issue_en_addsub gated by exec-stage valid
- alu_v0_o  out  256  bits[31:0] = mask slice for exec beat, bits[255:32] = 0
- wb_en_o  out  1  writeback strobe (exec cycle)
- wb_addr_o  out  5; wb_beat_o  out  $clog2(NB); wb_be_o  out  32  byte enables
- done_o  out  1  one-cycle pulse at instruction completion
- err_o  out  1  pulses with done_o on illegal SEW

## Operation

- EPB (elements per beat) = 32 >> sew: 32, 16, 8, 4.
- VLMAX = VLEN >> (3+sew); effective vl = min(issue_vl_i, VLMAX). Beats N = ceil(vl/EPB).
- Illegal SEW: treated as vl = 0, err_o = 1 with done_o.
- States:
  - IDLE: issue_ready_o = 1. On accept, latch all fields and v0_i; go to RUN if N > 0, else DRAIN.
  - RUN: rf_rd_en_o = 1 with rd beat counter b. On rf_rd_en_o & rf_gnt_i, exec stage loads beat b and b increments. When beat N-1 is granted, go to DRAIN. If no grant, hold request and outputs, and exec stage is empty next cycle.
  - DRAIN: completes the pending exec beat if any; done_o = 1; next state IDLE.
- Exec stage, one cycle after grant:
  - wb_en_o = 1, wb_addr_o = vd, wb_beat_o = beat.
  - alu_v0_o[k] = v0[beat*EPB + k] for k < EPB, 0 otherwise.
  - Element k enabled iff beat*EPB + k < vl, AND (use_mask = 1 OR v0 bit = 1).
  - wb_be_o sets all SEW/8 bytes of each enabled element; bytes beyond EPB elements are 0.
- vs1 = vd or vs2 = vd is legal: beats are disjoint.
- No second instruction is accepted until DRAIN completes.

## Timing

- Reset values: state IDLE, issue_ready_o = 1, all other outputs 0 (alu_* control 0, alu_v0_o 0).
- Reset mid-operation abandons the instruction: no wb_en_o and no done_o on the following cycles.
- Accept at cycle 0 with continuous grant:
  - reads at cycles 1..N
  - writebacks at cycles 2..N+1
  - done_o at cycle N+1
  - issue_ready_o high at cycle N+2
- vl = 0 or illegal SEW: done_o at cycle 1, no rd/wb, ready at cycle 2.
- Each grant stall adds exactly one cycle. A read and the previous beat's writeback coincide in the same cycle.
- Read/exec pipeline has no backpressure; writeback always completes.

## Test plan

- e32, vl=8, unmasked, vd=3:
  - one read at cycle 1 and one wb at cycle 2 with be=0xFFFFFFFF, beat 0
  - done_o at cycle 2
- e8, vl=100:
  - 4 beats; wb_be for beats 0-2 = 0xFFFFFFFF, beat 3 = 0x0000000F
  - done_o at cycle 5
- e64, vl=20 (VLMAX=16), rf_gnt_i low on cycles 2 and 3:
  - 4 beats, reads at cycles 1,4,5,6, wb at cycles 2,5,6,7
  - every be = 0xFFFFFFFF; done_o at cycle 7
- e16, vl=16, masked, v0 low 16 bits = 0xA5A5:
  - alu_v0_o = 0x0000A5A5
  - wb_be = 0xCC33CC33
- sew=5, vl=10: no read/wb; done_o and err_o at cycle 1; ready at cycle 2.
- e8, vl=128, rst_i asserted at cycle 3: no wb_en_o and no done_o afterward; ready and all outputs at reset values from cycle 4.
